// File: rtl/alpu_issue_pipe.sv
// ---------------------------------------------------------------------------
// alpu_issue_pipe
//
// Two-stage issue/retire wrapper around the external ALPU combinational
// datapath. An incoming op is decoded into the datapath control word when it
// is accepted and held in the issue register (S1). S1 drives the datapath
// directly. The datapath result is captured into the retire register (S2) on
// the S1->S2 transfer. An architectural carry flag is kept for ADC.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_ready     op input handshake (in_op, in_a, in_b, in_tag)
//   alu_a/alu_b/alu_ctrl/alu_cin   to the combinational datapath
//   alu_out/alu_cout               from the combinational datapath
//   out_valid/out_ready   result handshake (out_data, out_tag, out_cout, out_err)
//   carry_flag            architectural carry flag
//
// Handshake rule, both sides: a transfer happens on a rising edge where
// valid & ready are both high. A producer holds valid and its payload
// steady until that transfer. Ready may depend combinationally on the
// downstream ready (out_ready -> in_ready), never on in_valid.
// ---------------------------------------------------------------------------
module alpu_issue_pipe #(
  parameter int REG_WIDTH = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [REG_WIDTH-1:0] in_a,
  input  logic [REG_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [REG_WIDTH-1:0] alu_a,
  output logic [REG_WIDTH-1:0] alu_b,
  output logic [7:0]           alu_ctrl,
  output logic                 alu_cin,
  input  logic [REG_WIDTH-1:0] alu_out,
  input  logic                 alu_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_cout,
  output logic                 out_err,
  output logic                 carry_flag
);

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADC   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_NAND  = 4'h7;
  localparam logic [3:0] OP_NOR   = 4'h8;
  localparam logic [3:0] OP_XNOR  = 4'h9;
  localparam logic [3:0] OP_PASSB = 4'hA;

  // ---------------- state ----------------
  logic                 s1_valid_q, s1_valid_d;
  logic [REG_WIDTH-1:0] s1_a_q,     s1_a_d;
  logic [REG_WIDTH-1:0] s1_b_q,     s1_b_d;
  logic [7:0]           s1_ctrl_q,  s1_ctrl_d;
  logic                 s1_adc_q,   s1_adc_d;
  logic                 s1_arith_q, s1_arith_d;
  logic                 s1_err_q,   s1_err_d;
  logic [TAG_WIDTH-1:0] s1_tag_q,   s1_tag_d;

  logic                 out_valid_q, out_valid_d;
  logic [REG_WIDTH-1:0] out_data_q,  out_data_d;
  logic [TAG_WIDTH-1:0] out_tag_q,   out_tag_d;
  logic                 out_cout_q,  out_cout_d;
  logic                 out_err_q,   out_err_d;
  logic                 carry_flag_q, carry_flag_d;

  // ---------------- decode ----------------
  logic [7:0] dec_ctrl;
  logic       dec_adc;
  logic       dec_arith;
  logic       dec_err;
  logic       dec_zero_a;

  always_comb begin
    dec_ctrl   = 8'h00;
    dec_adc    = 1'b0;
    dec_arith  = 1'b0;
    dec_err    = 1'b0;
    dec_zero_a = 1'b0;
    case (in_op)
      OP_ADD:   begin dec_ctrl = 8'h2C; dec_arith = 1'b1; end
      OP_ADC:   begin dec_ctrl = 8'h2C; dec_arith = 1'b1; dec_adc = 1'b1; end
      OP_SUB:   begin dec_ctrl = 8'hAC; dec_arith = 1'b1; end
      OP_AND:   dec_ctrl = 8'h22;
      OP_OR:    dec_ctrl = 8'h32;
      OP_XOR:   dec_ctrl = 8'h04;
      OP_NOT:   dec_ctrl = 8'h44;
      OP_NAND:  dec_ctrl = 8'h23;
      OP_NOR:   dec_ctrl = 8'h33;
      OP_XNOR:  dec_ctrl = 8'h05;
      // PASSB reuses the OR control word with a zeroed A operand.
      OP_PASSB: begin dec_ctrl = 8'h32; dec_zero_a = 1'b1; end
      default:  dec_err = 1'b1;
    endcase
  end

  // ---------------- flow control ----------------
  logic s2_free;
  logic s1_adv;
  logic in_fire;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  // Held low during reset so nothing is accepted on the clearing edge.
  assign in_ready = !reset && (!s1_valid_q || s1_adv);
  assign in_fire  = in_valid && in_ready;

  // ---------------- next state ----------------
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_ctrl_d    = s1_ctrl_q;
    s1_adc_d     = s1_adc_q;
    s1_arith_d   = s1_arith_q;
    s1_err_d     = s1_err_q;
    s1_tag_d     = s1_tag_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_tag_d    = out_tag_q;
    out_cout_d   = out_cout_q;
    out_err_d    = out_err_q;
    carry_flag_d = carry_flag_q;

    // S1: reload on accept, empty on advance without a new op.
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = dec_zero_a ? '0 : in_a;
      s1_b_d     = in_b;
      s1_ctrl_d  = dec_ctrl;
      s1_adc_d   = dec_adc;
      s1_arith_d = dec_arith;
      s1_err_d   = dec_err;
      s1_tag_d   = in_tag;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // S2: reload on S1 advance (also covers a same-cycle retire), else
    // drain on consumer accept.
    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_data_d  = s1_err_q ? '0 : alu_out;
      out_tag_d   = s1_tag_q;
      out_cout_d  = s1_arith_q && alu_cout;
      out_err_d   = s1_err_q;
      if (s1_arith_q) begin
        carry_flag_d = alu_cout;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_ctrl_q    <= 8'h00;
      s1_adc_q     <= 1'b0;
      s1_arith_q   <= 1'b0;
      s1_err_q     <= 1'b0;
      s1_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_tag_q    <= '0;
      out_cout_q   <= 1'b0;
      out_err_q    <= 1'b0;
      carry_flag_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_ctrl_q    <= s1_ctrl_d;
      s1_adc_q     <= s1_adc_d;
      s1_arith_q   <= s1_arith_d;
      s1_err_q     <= s1_err_d;
      s1_tag_q     <= s1_tag_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_tag_q    <= out_tag_d;
      out_cout_q   <= out_cout_d;
      out_err_q    <= out_err_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  // ---------------- outputs ----------------
  assign alu_a      = s1_a_q;
  assign alu_b      = s1_b_q;
  assign alu_ctrl   = s1_ctrl_q;
  // Live flag, so an ADC right behind an ADD sees the freshly written carry.
  assign alu_cin    = s1_adc_q && carry_flag_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_tag    = out_tag_q;
  assign out_cout   = out_cout_q;
  assign out_err    = out_err_q;
  assign carry_flag = carry_flag_q;

endmodule
